// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shift_sequencer
// Description : Multi-cycle shifter, at most 7 bit positions per cycle, with
//               valid/ready request and result handshakes.
//               Define SHIFT_SEQ_ROTATE_EN to make mode 11 rotate right.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] amt_in,
    input  logic [1:0]       mode_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             carry_out,
    output logic             zero_out,
    output logic             busy
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    localparam logic [1:0] c_MODE_LSR = 2'b00;
    localparam logic [1:0] c_MODE_ASR = 2'b01;
    localparam logic [1:0] c_MODE_LSL = 2'b10;
    localparam logic [1:0] c_MODE_ROR = 2'b11;

    localparam logic [AMT_W-1:0] c_MAX_STEP = AMT_W'(7);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_operand;
    logic [AMT_W-1:0] r_remaining;
    logic [1:0]       r_mode;
    logic             r_carry;
    logic             r_zero;

    logic [2:0]       w_step;
    logic             w_fill;
    logic [WIDTH-1:0] w_right;
    logic             w_right_carry;
    logic [WIDTH-1:0] w_left;
    logic             w_left_carry;
    logic [WIDTH-1:0] w_next_operand;
    logic             w_step_carry;
    logic             w_saturated;
    logic [AMT_W-1:0] w_rem_next;
    logic [1:0]       w_cap_mode;
    logic [AMT_W-1:0] w_cap_amt;

`ifdef SHIFT_SEQ_ROTATE_EN
    logic [WIDTH-1:0] w_rot;

    // Rotation wraps every WIDTH positions, so only the residue needs stepping.
    assign w_cap_mode = mode_in;
    assign w_cap_amt  = (mode_in == c_MODE_ROR) ? AMT_W'(32'(amt_in) % WIDTH) : amt_in;
    assign w_rot      = WIDTH'({r_operand, r_operand} >> w_step);
`else
    assign w_cap_mode = (mode_in == c_MODE_ROR) ? c_MODE_LSR : mode_in;
    assign w_cap_amt  = amt_in;
`endif

    assign w_step        = (r_remaining > c_MAX_STEP) ? 3'd7 : r_remaining[2:0];
    assign w_fill        = (r_mode == c_MODE_ASR) & r_operand[WIDTH-1];
    assign w_right       = WIDTH'({{WIDTH{w_fill}}, r_operand} >> w_step);
    assign w_right_carry = 1'({r_operand, 1'b0} >> w_step);
    assign w_left        = r_operand << w_step;
    assign w_left_carry  = 1'(({1'b0, r_operand} << w_step) >> WIDTH);
    assign w_rem_next    = r_remaining - AMT_W'(w_step);

    always_comb begin
        w_next_operand = w_right;
        w_step_carry   = w_right_carry;
        case (r_mode)
            c_MODE_LSL: begin
                w_next_operand = w_left;
                w_step_carry   = w_left_carry;
            end
`ifdef SHIFT_SEQ_ROTATE_EN
            c_MODE_ROR: begin
                w_next_operand = w_rot;
                w_step_carry   = w_right_carry;
            end
`endif
            default: begin
                w_next_operand = w_right;
                w_step_carry   = w_right_carry;
            end
        endcase
    end

    // Once every bit equals the fill value, further steps cannot change the
    // result and every remaining bit shifted out would be the fill bit.
`ifdef SHIFT_SEQ_ROTATE_EN
    assign w_saturated = (r_mode != c_MODE_ROR) && (w_next_operand == {WIDTH{w_fill}});
`else
    assign w_saturated = (w_next_operand == {WIDTH{w_fill}});
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_operand   <= '0;
            r_remaining <= '0;
            r_mode      <= '0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_operand   <= data_in;
                        r_remaining <= w_cap_amt;
                        r_mode      <= w_cap_mode;
                        r_carry     <= 1'b0;
                        r_zero      <= 1'b0;
                        r_state     <= c_SHIFT;
                    end
                end
                c_SHIFT: begin
                    if (r_remaining == '0) begin
                        r_zero  <= (r_operand == '0);
                        r_state <= c_DONE;
                    end else begin
                        r_operand   <= w_next_operand;
                        r_remaining <= w_rem_next;
                        r_zero      <= (w_next_operand == '0);
                        r_carry     <= (w_rem_next != '0 && w_saturated) ? w_fill : w_step_carry;
                        if (w_rem_next == '0 || w_saturated) begin
                            r_state <= c_DONE;
                        end
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = (r_state == c_DONE);
    assign busy      = (r_state != c_IDLE);
    assign data_out  = r_operand;
    assign carry_out = r_carry;
    assign zero_out  = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// Testbench for shift_sequencer: directed cases plus randomized requests
// checked against an exact-arithmetic reference model.
module tb_shift_sequencer;

    localparam int WIDTH = 8;
    localparam int AMT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;
    logic [AMT_W-1:0] amt_in;
    logic [1:0]       mode_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic             carry_out;
    logic             zero_out;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .amt_in    (amt_in),
        .mode_in   (mode_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .carry_out (carry_out),
        .zero_out  (zero_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Exact shift semantics: shift the whole amount at once in a 64-bit value.
    function automatic void model(input logic [7:0] d, input logic [7:0] a, input logic [1:0] m,
                                  output logic [7:0] r, output logic c);
        logic signed [63:0] v;
        logic signed [63:0] t;
        logic [1:0]         mm;
        int                 e;
        mm = m;
`ifndef SHIFT_SEQ_ROTATE_EN
        if (mm == 2'b11) mm = 2'b00;
`endif
        c = 1'b0;
        if (mm == 2'b11) begin
            e = int'(a) % WIDTH;
            for (int k = 0; k < WIDTH; k++) r[k] = d[(k + e) % WIDTH];
            if (e != 0) c = d[e-1];
        end else if (mm == 2'b10) begin
            v = {56'd0, d};
            t = v << a;
            r = t[7:0];
            if (a != 0) begin
                t = v << (a - 1);
                c = t[7];
            end
        end else begin
            v = (mm == 2'b01) ? {{56{d[7]}}, d} : {56'd0, d};
            t = v >>> a;
            r = t[7:0];
            if (a != 0) begin
                t = v >>> (a - 1);
                c = t[0];
            end
        end
    endfunction

    function automatic int max_latency(input logic [7:0] a, input logic [1:0] m);
        int amt;
        int steps;
        amt = int'(a);
`ifdef SHIFT_SEQ_ROTATE_EN
        if (m == 2'b11) amt = amt % WIDTH;
`else
        if (m == 2'b11) amt = int'(a);
`endif
        steps = (amt + 6) / 7;
        if (steps < 1) steps = 1;
        return 1 + steps;
    endfunction

    task automatic wait_valid(input string tag, input int bound, output int lat);
        lat = 1;
        while (!out_valid && lat < bound + 3) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "/out_valid_timeout"}, out_valid, 1'b1);
    endtask

    task automatic run_op(input logic [7:0] d, input logic [7:0] a, input logic [1:0] m,
                          input int hold, input string tag, output int lat);
        logic [7:0] er;
        logic       ec;
        int         bound;
        model(d, a, m, er, ec);
        bound = max_latency(a, m);
        @(negedge clk);
        check({tag, "/in_ready_idle"}, in_ready, 1'b1);
        data_in   = d;
        amt_in    = a;
        mode_in   = m;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        data_in  = 8'($urandom);
        amt_in   = 8'($urandom);
        mode_in  = 2'($urandom);
        check({tag, "/busy_shift"}, busy, 1'b1);
        check({tag, "/in_ready_shift"}, in_ready, 1'b0);
        wait_valid(tag, bound, lat);
        check({tag, "/latency_in_range"}, (lat >= 2 && lat <= bound), 1'b1);
`ifdef SHIFT_SEQ_ROTATE_EN
        if (m == 2'b11) check({tag, "/rotate_latency"}, lat, bound);
`endif
        check({tag, "/data"}, data_out, er);
        check({tag, "/carry"}, carry_out, ec);
        check({tag, "/zero"}, zero_out, (er == 8'd0));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "/hold_valid"}, out_valid, 1'b1);
            check({tag, "/hold_in_ready"}, in_ready, 1'b0);
            check({tag, "/hold_data"}, data_out, er);
            check({tag, "/hold_carry"}, carry_out, ec);
            check({tag, "/hold_zero"}, zero_out, (er == 8'd0));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "/valid_drop"}, out_valid, 1'b0);
        check({tag, "/in_ready_back"}, in_ready, 1'b1);
    endtask

    initial begin
        int         lat;
        int         rises;
        logic [7:0] rd;
        logic [7:0] ra;
        logic [1:0] rm;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        amt_in    = '0;
        mode_in   = '0;
        repeat (2) @(negedge clk);
        check("reset/in_ready", in_ready, 1'b1);
        check("reset/out_valid", out_valid, 1'b0);
        check("reset/data_out", data_out, 8'h00);
        check("reset/carry_out", carry_out, 1'b0);
        check("reset/zero_out", zero_out, 1'b0);
        check("reset/busy", busy, 1'b0);
        rst_n = 1'b1;

        run_op(8'h96, 8'd3, 2'b01, 0, "asr_0x96_3", lat);
        check("asr_0x96_3/latency", lat, 2);
        run_op(8'h01, 8'd10, 2'b10, 0, "lsl_0x01_10", lat);
        run_op(8'h80, 8'd200, 2'b01, 0, "asr_sat_200", lat);
        check("asr_sat_200/within3", (lat <= 3), 1'b1);
        run_op(8'hFF, 8'd20, 2'b00, 5, "lsr_backpressure", lat);
        check("lsr_backpressure/latency", lat, 3);
        run_op(8'h5A, 8'd0, 2'b00, 0, "amt_zero", lat);
        check("amt_zero/latency", lat, 2);
        run_op(8'h40, 8'd8, 2'b01, 1, "asr_amt_width", lat);
        run_op(8'hA5, 8'd12, 2'b11, 0, "mode11_0xA5_12", lat);

        // Result handshake and a new request in the same cycle.
        run_op(8'h3C, 8'd2, 2'b00, 0, "pre_overlap", lat);
        @(negedge clk);
        data_in  = 8'h3C; amt_in = 8'd2; mode_in = 2'b00; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid("overlap_first", 2, lat);
        data_in   = 8'h55; amt_in = 8'd1; mode_in = 2'b10;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("overlap/not_accepted_busy", busy, 1'b0);
        check("overlap/in_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check("overlap/accepted_next", busy, 1'b1);
        wait_valid("overlap_second", 2, lat);
        check("overlap/data", data_out, 8'hAA);
        check("overlap/carry", carry_out, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset during SHIFT drops the request.
        data_in = 8'h01; amt_in = 8'd100; mode_in = 2'b10; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("abort/busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort/busy", busy, 1'b0);
        check("abort/out_valid", out_valid, 1'b0);
        check("abort/data_out", data_out, 8'h00);
        rises = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) rises++;
        end
        check("abort/no_out_valid", rises, 0);
        check("abort/in_ready", in_ready, 1'b1);

        for (int n = 0; n < 60; n++) begin
            rd = 8'($urandom);
            ra = (n % 2 == 0) ? 8'($urandom_range(0, 24)) : 8'($urandom);
            rm = 2'($urandom);
            if (n % 7 == 0) rd = (n % 14 == 0) ? 8'hFF : 8'h80;
            run_op(rd, ra, rm, $urandom_range(0, 2), $sformatf("rand%0d_d%0h_a%0d_m%0d", n, rd, ra, rm), lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
